// File: rtl/qpu_tevq_pkg.sv
// Shared widths and entry layout for the EXU time/event queue.
`ifndef QPU_TIME_WIDTH
`define QPU_TIME_WIDTH 12
`endif
`ifndef QPU_EVENT_WIRE_WIDTH
`define QPU_EVENT_WIRE_WIDTH 8
`endif
`ifndef QPU_EVENT_NUM
`define QPU_EVENT_NUM 4
`endif
`ifndef QPU_TWO_QUBIT_GATE_LIST_WIDTH
`define QPU_TWO_QUBIT_GATE_LIST_WIDTH 6
`endif

package qpu_tevq_pkg;

  localparam int unsigned QpuTw = `QPU_TIME_WIDTH;
  localparam int unsigned QpuEw = `QPU_EVENT_WIRE_WIDTH;
  localparam int unsigned QpuEn = `QPU_EVENT_NUM;
  localparam int unsigned QpuTq = `QPU_TWO_QUBIT_GATE_LIST_WIDTH;

  typedef struct packed {
    logic [QpuTw-1:0] time_pt;
    logic [QpuEw-1:0] data;
    logic [QpuEn-1:0] oprand;
    logic [QpuTq-1:0] tqgl;
  } tevq_entry_t;

  localparam int unsigned EntryW = $bits(tevq_entry_t);

endpackage

// File: rtl/qpu_sync_fifo.sv
// Synchronous FIFO with clear; control state is reset, the storage array is not.
module qpu_sync_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8,
  localparam int unsigned Aw = $clog2(Depth),
  localparam int unsigned Cw = Aw + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic [Cw-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wr_ptr_q, rd_ptr_q;
  logic [Cw-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == Cw'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o & ~clr_i;
  assign do_pop  = pop_i & ~empty_o & ~clr_i;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally.
      if (do_push) wr_ptr_q <= wr_ptr_q + Aw'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + Aw'(1);
      count_q <= count_q + Cw'(do_push) - Cw'(do_pop);
    end
  end

endmodule

// File: rtl/qpu_exu_tevq.sv
// Time/event queue: holds timed events from write-back and releases each when the
// local timer reaches its time point.
module qpu_exu_tevq
  import qpu_tevq_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TW    = QpuTw,
  parameter int unsigned EW    = QpuEw,
  parameter int unsigned EN    = QpuEn,
  parameter int unsigned TQ    = QpuTq,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tiq_wbck_i_ena,
  input  logic [TW-1:0] tiq_wbck_i_data,
  output logic          tiq_wbck_i_ready,
  input  logic          evq_wbck_i_ena,
  output logic          evq_wbck_i_ready,
  input  logic [EW-1:0] evq_wbck_i_data,
  input  logic [EN-1:0] evq_wbck_i_oprand,
  input  logic [TQ-1:0] evq_wbck_i_tqgl,
  input  logic          timer_clr_i,
  output logic          evt_o_valid,
  output logic [TW-1:0] evt_o_time,
  output logic [EW-1:0] evt_o_data,
  output logic [EN-1:0] evt_o_oprand,
  output logic [TQ-1:0] evt_o_tqgl,
  output logic [TW-1:0] timer_o,
  output logic [CW-1:0] count_o,
  output logic          late_err_o,
  output logic          proto_err_o
);

  localparam int unsigned W = TW + EW + EN + TQ;
  localparam logic [TW-1:0] TimerMax = {TW{1'b1}};

  logic          full, empty, ready, mismatch, push, pop;
  logic [W-1:0]  head;
  logic [TW-1:0] head_time;
  logic [TW-1:0] timer_q, timer_d;
  logic          run_q, run_d;
  logic          late_q, late_d, proto_q, proto_d;
  logic          evt_valid_q, evt_valid_d;
  logic [W-1:0]  evt_q, evt_d;

  qpu_sync_fifo #(
    .Depth (DEPTH),
    .Width (W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (timer_clr_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({tiq_wbck_i_data, evq_wbck_i_data, evq_wbck_i_oprand, evq_wbck_i_tqgl}),
    .rdata_o (head),
    .count_o (count_o),
    .full_o  (full),
    .empty_o (empty)
  );

  assign ready            = ~full;
  assign tiq_wbck_i_ready = ready;
  assign evq_wbck_i_ready = ready;
  assign mismatch         = tiq_wbck_i_ena ^ evq_wbck_i_ena;
  assign push             = tiq_wbck_i_ena & ~mismatch & ready & ~timer_clr_i;
  assign head_time        = head[W-1 -: TW];
  // Registered count gates the compare, so a same-cycle push into an empty queue cannot fire.
  assign pop              = ~empty & run_q & (timer_q >= head_time) & ~timer_clr_i;

  always_comb begin
    timer_d     = timer_q;
    run_d       = run_q;
    late_d      = late_q | (pop & (timer_q > head_time));
    proto_d     = proto_q | mismatch | ((tiq_wbck_i_ena | evq_wbck_i_ena) & full);
    evt_valid_d = pop;
    evt_d       = pop ? head : evt_q;
    if (run_q) begin
      if (timer_q != TimerMax) timer_d = timer_q + TW'(1);
    end else if (push) begin
      run_d   = 1'b1;
      timer_d = '0;
    end
    if (timer_clr_i) begin
      timer_d     = '0;
      run_d       = 1'b0;
      late_d      = 1'b0;
      proto_d     = 1'b0;
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q     <= '0;
      run_q       <= 1'b0;
      late_q      <= 1'b0;
      proto_q     <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_q       <= '0;
    end else begin
      timer_q     <= timer_d;
      run_q       <= run_d;
      late_q      <= late_d;
      proto_q     <= proto_d;
      evt_valid_q <= evt_valid_d;
      evt_q       <= evt_d;
    end
  end

  assign timer_o      = timer_q;
  assign late_err_o   = late_q;
  assign proto_err_o  = proto_q;
  assign evt_o_valid  = evt_valid_q;
  assign evt_o_time   = evt_q[W-1 -: TW];
  assign evt_o_data   = evt_q[EN+TQ +: EW];
  assign evt_o_oprand = evt_q[TQ +: EN];
  assign evt_o_tqgl   = evt_q[TQ-1:0];

endmodule

// File: tb/tb_qpu_exu_tevq.sv
// Self-checking bench for qpu_exu_tevq: vector table plus release scoreboard.
module tb_qpu_exu_tevq;
  import qpu_tevq_pkg::*;

  localparam int unsigned Depth = 16;
  localparam int unsigned Cw    = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tiq_ena = 1'b0, evq_ena = 1'b0, clr = 1'b0;
  logic [QpuTw-1:0] tiq_data = '0;
  logic [QpuEw-1:0] evq_data = '0;
  logic [QpuEn-1:0] evq_op = '0;
  logic [QpuTq-1:0] evq_tq = '0;
  logic             tiq_ready, evq_ready, evt_valid, late_err, proto_err;
  logic [QpuTw-1:0] evt_time, timer;
  logic [QpuEw-1:0] evt_data;
  logic [QpuEn-1:0] evt_op;
  logic [QpuTq-1:0] evt_tq;
  logic [Cw-1:0]    count;

  always #5 clk = ~clk;

  qpu_exu_tevq #(.DEPTH(Depth)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .tiq_wbck_i_ena    (tiq_ena),
    .tiq_wbck_i_data   (tiq_data),
    .tiq_wbck_i_ready  (tiq_ready),
    .evq_wbck_i_ena    (evq_ena),
    .evq_wbck_i_ready  (evq_ready),
    .evq_wbck_i_data   (evq_data),
    .evq_wbck_i_oprand (evq_op),
    .evq_wbck_i_tqgl   (evq_tq),
    .timer_clr_i       (clr),
    .evt_o_valid       (evt_valid),
    .evt_o_time        (evt_time),
    .evt_o_data        (evt_data),
    .evt_o_oprand      (evt_op),
    .evt_o_tqgl        (evt_tq),
    .timer_o           (timer),
    .count_o           (count),
    .late_err_o        (late_err),
    .proto_err_o       (proto_err)
  );

  typedef struct {
    tevq_entry_t e;
    int          cyc;
  } sb_t;

  typedef struct {
    int               grp;
    logic [QpuTw-1:0] t;
    logic [QpuEw-1:0] d;
    logic [QpuEn-1:0] op;
    logic [QpuTq-1:0] tq;
    int               rel;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[7];
  logic late_exp[3];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic tevq_entry_t mk(input logic [QpuTw-1:0] t, input logic [QpuEw-1:0] d,
                                     input logic [QpuEn-1:0] op, input logic [QpuTq-1:0] tq);
    tevq_entry_t e;
    e.time_pt = t;
    e.data    = d;
    e.oprand  = op;
    e.tqgl    = tq;
    return e;
  endfunction

  // Advance one cycle, sample #1 after the edge and score any release.
  task automatic tick();
    sb_t s;
    @(posedge clk);
    #1;
    cyc++;
    if (evt_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_release", 64'd1, 64'd0);
      end else begin
        s = sb.pop_front();
        chk("release_payload", 64'({evt_time, evt_data, evt_op, evt_tq}), 64'(s.e));
        chk("release_cycle", 64'(cyc), 64'(s.cyc));
      end
    end
  endtask

  task automatic drive(input tevq_entry_t e);
    tiq_ena  = 1'b1;
    evq_ena  = 1'b1;
    tiq_data = e.time_pt;
    evq_data = e.data;
    evq_op   = e.oprand;
    evq_tq   = e.tqgl;
  endtask

  task automatic idle();
    tiq_ena = 1'b0;
    evq_ena = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    for (int k = 0; k < bound && sb.size() != 0; k++) tick();
    chk("drain_pending", 64'(sb.size()), 64'd0);
    tick();
    tick();
  endtask

  initial begin
    int          b;
    bit          first;
    tevq_entry_t e;

    vecs[0] = '{0, 12'd3,  8'hA1, 4'h1, 6'h01, 5};
    vecs[1] = '{1, 12'd5,  8'hB1, 4'h2, 6'h02, 7};
    vecs[2] = '{1, 12'd5,  8'hB2, 4'h3, 6'h03, 8};
    vecs[3] = '{1, 12'd7,  8'hB3, 4'h4, 6'h04, 9};
    vecs[4] = '{2, 12'd2,  8'hC1, 4'h5, 6'h05, 4};
    vecs[5] = '{2, 12'd10, 8'hC2, 4'h6, 6'h06, 12};
    vecs[6] = '{2, 12'd4,  8'hC3, 4'h7, 6'h07, 13};
    late_exp = '{1'b0, 1'b1, 1'b1};

    // Reset state
    #3;
    chk("rst_valid", 64'(evt_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_timer", 64'(timer), 64'd0);
    chk("rst_flags", 64'({late_err, proto_err}), 64'd0);
    #9 rst_n = 1'b1;
    tick();
    chk("rst_ready", 64'({tiq_ready, evq_ready}), 64'b11);

    // Table-driven release groups
    for (int g = 0; g < 3; g++) begin
      do_clear();
      b = cyc;
      first = 1'b1;
      for (int i = 0; i < 7; i++) begin
        if (vecs[i].grp == g) begin
          e = mk(vecs[i].t, vecs[i].d, vecs[i].op, vecs[i].tq);
          drive(e);
          sb.push_back('{e, b + vecs[i].rel});
          tick();
          if (first) chk("timer_start", 64'(timer), 64'd0);
          first = 1'b0;
        end
      end
      idle();
      wait_drain(100);
      chk("group_late", 64'(late_err), 64'(late_exp[g]));
    end

    // Enable mismatch: no push, protocol error
    do_clear();
    chk("clr_proto", 64'(proto_err), 64'd0);
    tiq_ena = 1'b1;
    evq_ena = 1'b0;
    tick();
    idle();
    chk("mismatch_count", 64'(count), 64'd0);
    chk("mismatch_proto", 64'(proto_err), 64'd1);

    // Fill to full, then push into full
    do_clear();
    b = cyc;
    for (int i = 0; i < Depth; i++) begin
      e = mk(12'd1000, 8'(i), 4'(i), 6'(i));
      drive(e);
      sb.push_back('{e, b + 1002 + i});
      tick();
    end
    chk("full_ready", 64'({tiq_ready, evq_ready}), 64'b00);
    chk("full_count", 64'(count), 64'(Depth));
    chk("full_proto_pre", 64'(proto_err), 64'd0);
    drive(mk(12'd1, 8'hFF, 4'hF, 6'h3F));
    tick();
    idle();
    chk("full_proto", 64'(proto_err), 64'd1);
    chk("full_count_hold", 64'(count), 64'(Depth));
    wait_drain(1100);
    chk("full_late", 64'(late_err), 64'd1);

    // Clear with pending entries and a concurrent push
    for (int i = 0; i < 4; i++) begin
      drive(mk(12'd4000, 8'(8'h40 + i), 4'h0, 6'h0));
      tick();
    end
    chk("pend_count", 64'(count), 64'd4);
    drive(mk(12'd0, 8'h77, 4'h7, 6'h07));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    idle();
    chk("clr_count", 64'(count), 64'd0);
    chk("clr_timer", 64'(timer), 64'd0);
    chk("clr_flags", 64'({late_err, proto_err}), 64'd0);
    for (int k = 0; k < 60; k++) tick();
    chk("clr_count_after", 64'(count), 64'd0);

    // Asynchronous reset mid-release
    b = cyc;
    for (int i = 0; i < 3; i++) begin
      e = mk(12'd2, 8'(8'h50 + i), 4'h9, 6'h11);
      drive(e);
      sb.push_back('{e, b + 4 + i});
      tick();
    end
    idle();
    tick();
    chk("mid_release_valid", 64'(evt_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(evt_valid), 64'd0);
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_timer", 64'(timer), 64'd0);
    sb.delete();
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 64'({tiq_ready, evq_ready}), 64'b11);
    chk("post_rst_count", 64'(count), 64'd0);

    // Timer saturation
    b = cyc;
    e = mk(12'hFFF, 8'h5A, 4'hA, 6'h2A);
    drive(e);
    sb.push_back('{e, b + 4097});
    tick();
    idle();
    for (int k = 0; k < 10; k++) tick();
    chk("timer_count", 64'(timer), 64'd10);
    wait_drain(4200);
    for (int k = 0; k < 5; k++) tick();
    chk("timer_saturate", 64'(timer), 64'hFFF);
    chk("sat_late", 64'(late_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
